// File: rtl/wr_dest_decoder_seq_pkg.sv
// ---------------------------------------------------------------------------
// wrdec_pkg
// Shared types and helpers for the write-destination decoder.
//   state_t         : decoder FSM states (IDLE, SEQ)
//   DEF_*           : default configuration constants
//   map_t           : decode result {hit, bcast, onehot}
//   code_to_onehot  : destination code -> decode result, configuration
//                     passed in so one function serves every parameter set
// No ports (package).
// ---------------------------------------------------------------------------
package wrdec_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_NUM_SRC    = 3;
    localparam int unsigned DEF_NUM_TGT    = 20;
    localparam int unsigned DEF_LIN_TGT    = 18;
    localparam int unsigned DEF_HI_BASE    = 21;
    localparam int unsigned DEF_BCAST_CODE = 31;

    // Upper bounds for the helper's working widths.
    localparam int unsigned MAX_ADDR_W = 16;
    localparam int unsigned MAX_TGT    = 64;

    typedef struct packed {
        logic               hit;
        logic               bcast;
        logic [MAX_TGT-1:0] onehot;
    } map_t;

    // Broadcast is tested before the range maps, so it wins any overlap.
    // The caller zero-extends its code, so every compare is exact at the
    // caller's own code width.
    function automatic map_t code_to_onehot(
        input logic [MAX_ADDR_W-1:0] code,
        input int unsigned           lin_tgt,
        input int unsigned           hi_base,
        input int unsigned           num_tgt,
        input int unsigned           bcast_code
    );
        map_t res;
        res = '0;
        if (code == MAX_ADDR_W'(bcast_code)) begin
            res.hit   = 1'b1;
            res.bcast = 1'b1;
        end else begin
            for (int unsigned i = 0; i < MAX_TGT; i++) begin
                if (i < lin_tgt) begin
                    if (code == MAX_ADDR_W'(i + 1)) begin
                        res.hit       = 1'b1;
                        res.onehot[i] = 1'b1;
                    end
                end else if (i < num_tgt) begin
                    if (code == MAX_ADDR_W'(hi_base + i - lin_tgt)) begin
                        res.hit       = 1'b1;
                        res.onehot[i] = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wr_dest_decoder_seq_if.sv
// ---------------------------------------------------------------------------
// wr_dest_decoder_seq_if
// Request / write-enable bundle of the write-destination decoder.
//   req_valid  : request present (master -> slave)
//   req_ready  : decoder can accept (slave -> master)
//   src_sel    : 0 = no write, s = use src_addr slice s-1
//   src_addr   : NUM_SRC packed destination codes of ADDR_W bits
//   wr_en      : registered write-enable vector, NUM_TGT bits
//   bcast_busy : sequenced broadcast in progress
//   dec_err    : one-cycle decode error pulse
// ---------------------------------------------------------------------------
interface wr_dest_decoder_seq_if
    import wrdec_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned NUM_TGT = DEF_NUM_TGT
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);

    logic                      req_valid;
    logic                      req_ready;
    logic [SEL_W-1:0]          src_sel;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_TGT-1:0]        wr_en;
    logic                      bcast_busy;
    logic                      dec_err;

    modport master (
        output req_valid, src_sel, src_addr,
        input  req_ready, wr_en, bcast_busy, dec_err
    );

    modport slave (
        input  req_valid, src_sel, src_addr,
        output req_ready, wr_en, bcast_busy, dec_err
    );

endinterface

// File: rtl/wr_dest_decoder_seq_code_map.sv
// ---------------------------------------------------------------------------
// wr_code_map
// Combinational destination-code decoder.
//   code   in  ADDR_W   selected destination code
//   hit    out 1        code is mapped (range target or broadcast)
//   bcast  out 1        code is the broadcast code
//   onehot out NUM_TGT  one-hot target for range hits, zero otherwise
// ---------------------------------------------------------------------------
module wr_code_map
    import wrdec_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_TGT    = DEF_NUM_TGT,
    parameter int unsigned LIN_TGT    = DEF_LIN_TGT,
    parameter int unsigned HI_BASE    = DEF_HI_BASE,
    parameter int unsigned BCAST_CODE = DEF_BCAST_CODE
) (
    input  logic [ADDR_W-1:0]  code,
    output logic               hit,
    output logic               bcast,
    output logic [NUM_TGT-1:0] onehot
);

    if (ADDR_W > MAX_ADDR_W) begin : g_chk_addr_w
        $error("wr_code_map: ADDR_W exceeds MAX_ADDR_W");
    end
    if (NUM_TGT > MAX_TGT) begin : g_chk_num_tgt
        $error("wr_code_map: NUM_TGT exceeds MAX_TGT");
    end

    map_t res;

    always_comb begin
        res = code_to_onehot(MAX_ADDR_W'(code), LIN_TGT, HI_BASE, NUM_TGT, BCAST_CODE);
    end

    assign hit    = res.hit;
    assign bcast  = res.bcast;
    assign onehot = res.onehot[NUM_TGT-1:0];

    if (NUM_TGT < MAX_TGT) begin : g_hi
        // Bits above NUM_TGT are always zero from the helper.
        logic unused_hi;
        assign unused_hi = ^res.onehot[MAX_TGT-1:NUM_TGT];
    end

endmodule

// File: rtl/wr_dest_decoder_seq.sv
// ---------------------------------------------------------------------------
// wr_dest_decoder_seq
// Write-destination decoder for the register-file / special-register path.
// One request per cycle selects a destination code from one of NUM_SRC
// sources; the code becomes a registered one-cycle write-enable pulse.
// Broadcast is either an all-ones pulse or a walk over every target.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : slave side of wr_dest_decoder_seq_if
//           (req_valid/req_ready, src_sel, src_addr,
//            wr_en, bcast_busy, dec_err)
// ---------------------------------------------------------------------------
module wr_dest_decoder_seq
    import wrdec_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned NUM_TGT    = DEF_NUM_TGT,
    parameter int unsigned LIN_TGT    = DEF_LIN_TGT,
    parameter int unsigned HI_BASE    = DEF_HI_BASE,
    parameter int unsigned BCAST_CODE = DEF_BCAST_CODE,
    parameter int unsigned SEQ_BCAST  = 0
) (
    input logic                   Clock,
    input logic                   Reset,
    wr_dest_decoder_seq_if.slave  bus
);

    localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);
    localparam int unsigned IDX_W = $clog2(NUM_TGT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TGT - 1);

    // Parameter sanity, checked at elaboration.
    if (NUM_SRC < 1) begin : g_chk_src
        $error("wr_dest_decoder_seq: NUM_SRC must be at least 1");
    end
    if (NUM_TGT < 2) begin : g_chk_tgt
        $error("wr_dest_decoder_seq: NUM_TGT must be at least 2");
    end
    if (LIN_TGT > NUM_TGT) begin : g_chk_lin
        $error("wr_dest_decoder_seq: LIN_TGT exceeds NUM_TGT");
    end
    if ((NUM_TGT > LIN_TGT) && (HI_BASE <= LIN_TGT)) begin : g_chk_overlap
        $error("wr_dest_decoder_seq: high code range overlaps linear range");
    end
    if ((NUM_TGT > LIN_TGT) &&
        ((HI_BASE + NUM_TGT - LIN_TGT - 1) >= (32'd1 << ADDR_W))) begin : g_chk_hi_w
        $error("wr_dest_decoder_seq: high code range does not fit ADDR_W");
    end
    if (BCAST_CODE >= (32'd1 << ADDR_W)) begin : g_chk_bc_w
        $error("wr_dest_decoder_seq: BCAST_CODE does not fit ADDR_W");
    end

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   walk_idx, walk_idx_nxt;
    logic [NUM_TGT-1:0] wr_en_q, wr_en_nxt;
    logic               dec_err_q, dec_err_nxt;

    logic [ADDR_W-1:0]  sel_code;
    logic               sel_none;
    logic               sel_found;
    logic               sel_bad;
    logic               map_hit;
    logic               map_bcast;
    logic [NUM_TGT-1:0] map_onehot;
    logic               req_ready;
    logic               bcast_busy;
    logic               accept;

    // ---------------- source mux ----------------
    always_comb begin
        sel_code  = '0;
        sel_found = 1'b0;
        sel_none  = (bus.src_sel == '0);
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (bus.src_sel == SEL_W'(s + 1)) begin
                sel_code  = bus.src_addr[s*ADDR_W +: ADDR_W];
                sel_found = 1'b1;
            end
        end
        // Any nonzero select that matched no source is out of range.
        sel_bad = !sel_none && !sel_found;
    end

    wr_code_map #(
        .ADDR_W     (ADDR_W),
        .NUM_TGT    (NUM_TGT),
        .LIN_TGT    (LIN_TGT),
        .HI_BASE    (HI_BASE),
        .BCAST_CODE (BCAST_CODE)
    ) u_map (
        .code   (sel_code),
        .hit    (map_hit),
        .bcast  (map_bcast),
        .onehot (map_onehot)
    );

    // Handshake status depends on state only.
    assign req_ready  = (state == IDLE);
    assign bcast_busy = (state == SEQ);
    assign accept     = bus.req_valid && req_ready;

    // ---------------- state register ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            walk_idx  <= '0;
            wr_en_q   <= '0;
            dec_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            walk_idx  <= walk_idx_nxt;
            wr_en_q   <= wr_en_nxt;
            dec_err_q <= dec_err_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt    = state;
        walk_idx_nxt = walk_idx;
        unique case (state)
            IDLE: begin
                if (accept && sel_found && map_bcast && (SEQ_BCAST != 0)) begin
                    // Bit 0 goes out with the acceptance; the walk resumes at 1.
                    state_nxt    = SEQ;
                    walk_idx_nxt = IDX_W'(1);
                end
            end
            SEQ: begin
                // Leaving on the last bit lets ready rise alongside it.
                if (walk_idx == LAST_IDX) begin
                    state_nxt    = IDLE;
                    walk_idx_nxt = '0;
                end else begin
                    walk_idx_nxt = walk_idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                walk_idx_nxt = '0;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        wr_en_nxt   = '0;
        dec_err_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !sel_none) begin
                    if (sel_bad || !map_hit) begin
                        dec_err_nxt = 1'b1;
                    end else if (map_bcast) begin
                        wr_en_nxt = (SEQ_BCAST != 0) ? NUM_TGT'(1) : '1;
                    end else begin
                        wr_en_nxt = map_onehot;
                    end
                end
            end
            SEQ: begin
                wr_en_nxt = NUM_TGT'(1) << walk_idx;
            end
            default: begin
                wr_en_nxt = '0;
            end
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.bcast_busy = bcast_busy;
    assign bus.wr_en      = wr_en_q;
    assign bus.dec_err    = dec_err_q;

endmodule
